// File: rtl/uart_rx_deser.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx_deser
// Brief    : UART receive deserializer driven by an oversampled baud tick.
//            Recovers framed words with optional parity and reports errors.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx_deser #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic                 tick_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int c_CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_sync;
    logic                   w_rxs;
    logic [c_CNT_W-1:0]     r_tick_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_data_valid;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   w_sample;
    logic                   w_tick_en;
    logic                   w_busy;
    logic                   w_par_exp;

    assign w_rxs = r_sync[1];

    // Both stages reset high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    // Start waits half a bit to land on the centre; later bits wait a full bit.
    always_comb begin
        w_sample = 1'b0;
        if (rx_tick) begin
            case (r_state)
                S_START:                   w_sample = (r_tick_cnt == c_HALF);
                S_DATA, S_PARITY, S_STOP:  w_sample = (r_tick_cnt == c_FULL);
                default:                   w_sample = 1'b0;
            endcase
        end
    end

    assign w_par_exp = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_en    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (!w_rxs) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tick_en = 1'b1;
                if (w_sample) begin
                    w_state_next = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_tick_en = 1'b1;
                if (w_sample && (r_bit_cnt == c_LAST_BIT)) begin
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tick_en = 1'b1;
                if (w_sample) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                w_tick_en = 1'b1;
                // A low stop bit parks in BREAK so it cannot pose as a new start.
                if (w_sample) begin
                    w_state_next = w_rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rxs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;

            // A tick coinciding with a transition belongs to the old state only.
            if ((w_state_next != r_state) || w_sample) begin
                r_tick_cnt <= '0;
            end else if (rx_tick && w_tick_en) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            case (r_state)
                S_START: begin
                    if (w_sample) begin
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= w_rxs;
                        r_bit_cnt          <= r_bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_err <= (w_rxs != w_par_exp);
                    end
                end
                S_STOP: begin
                    if (w_sample) begin
                        r_data       <= r_shift;
                        r_frame_err  <= ~w_rxs;
                        r_parity_err <= (PARITY != 0) ? r_par_err : 1'b0;
                        r_data_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tick_en    = w_tick_en;
    assign busy       = w_busy;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx_deser
// Brief    : Bench for uart_rx_deser with none/even/odd parity instances.
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_rx_deser;

    localparam int c_DIV     = 4;
    localparam int c_OS      = 8;
    localparam int c_BIT_CLK = c_DIV * c_OS;
    localparam int c_NI      = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      rxd;
    logic [2:0]      rx_tick;
    logic [2:0]      tick_en;
    logic [2:0][7:0] data;
    logic [2:0]      data_valid;
    logic [2:0]      frame_err;
    logic [2:0]      parity_err;
    logic [2:0]      busy;

    int div_cnt  [c_NI];
    int n_valid  [c_NI] = '{0, 0, 0};
    int gap_low  [c_NI] = '{0, 0, 0};
    int last_gap [c_NI] = '{0, 0, 0};
    int n_tests = 0;
    int n_fail  = 0;

    // Expected record: {busy, parity_err, frame_err, data}
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(c_OS), .PARITY(0)) u_dut0 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick[0]), .rxd(rxd[0]), .tick_en(tick_en[0]),
        .data(data[0]), .data_valid(data_valid[0]), .frame_err(frame_err[0]),
        .parity_err(parity_err[0]), .busy(busy[0]));

    uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(c_OS), .PARITY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick[1]), .rxd(rxd[1]), .tick_en(tick_en[1]),
        .data(data[1]), .data_valid(data_valid[1]), .frame_err(frame_err[1]),
        .parity_err(parity_err[1]), .busy(busy[1]));

    uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(c_OS), .PARITY(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick[2]), .rxd(rxd[2]), .tick_en(tick_en[2]),
        .data(data[2]), .data_valid(data_valid[2]), .frame_err(frame_err[2]),
        .parity_err(parity_err[2]), .busy(busy[2]));

    // Baud generator stand-in: held in restart while tick_en is low.
    always @(posedge clk) begin
        for (int k = 0; k < c_NI; k++) begin
            if (rst || (tick_en[k] !== 1'b1)) begin
                div_cnt[k] <= 0;
                rx_tick[k] <= 1'b0;
            end else begin
                div_cnt[k] <= (div_cnt[k] == c_DIV - 1) ? 0 : div_cnt[k] + 1;
                rx_tick[k] <= (div_cnt[k] == c_DIV - 1);
            end
        end
    end

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic int par_mode(input int k);
        return k;
    endfunction

    function automatic void push_exp(input int k, input logic [10:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void check_frame(input int k);
        logic [10:0] e;
        if (q_size(k) == 0) begin
            check($sformatf("unexpected_valid%0d", k), 32'd1, 32'd0);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("data%0d", k),       32'(data[k]),       32'(e[7:0]));
        check($sformatf("frame_err%0d", k),  32'(frame_err[k]),  32'(e[8]));
        check($sformatf("parity_err%0d", k), 32'(parity_err[k]), 32'(e[9]));
        check($sformatf("busy_at_dv%0d", k), 32'(busy[k]),       32'(e[10]));
        check($sformatf("tick_en_at_dv%0d", k), 32'(tick_en[k]), 32'd0);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < c_NI; k++) begin
                if (data_valid[k] === 1'b1) begin
                    n_valid[k]++;
                    last_gap[k] = gap_low[k];
                    gap_low[k]  = 0;
                    check_frame(k);
                end else if (tick_en[k] === 1'b0) begin
                    gap_low[k]++;
                end
            end
        end
    end

    task automatic drive_bit(input int k, input logic b);
        @(negedge clk);
        rxd[k] = b;
        repeat (c_BIT_CLK - 1) @(negedge clk);
    endtask

    // Model: parity and errors from the framing rules using ones-count arithmetic.
    task automatic send_frame(input int k, input logic [7:0] d, input logic pbit, input logic stop);
        int   ones;
        logic exp_bit;
        logic exp_perr;
        ones     = $countones(d);
        exp_perr = 1'b0;
        if (par_mode(k) != 0) begin
            exp_bit  = (par_mode(k) == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            exp_perr = (pbit != exp_bit);
        end
        push_exp(k, {~stop, exp_perr, ~stop, d});
        drive_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(k, d[i]);
        end
        if (par_mode(k) != 0) begin
            drive_bit(k, pbit);
        end
        drive_bit(k, stop);
        check($sformatf("frame_received%0d", k), 32'(q_size(k)), 32'd0);
    endtask

    task automatic idle_gap(input int k, input int cycles);
        @(negedge clk);
        rxd[k] = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          v0;
        logic [7:0]  d;
        logic [7:0]  prev;
        rst = 1'b1;
        rxd = 3'b111;
        repeat (4) @(negedge clk);

        for (int k = 0; k < c_NI; k++) begin
            check($sformatf("rst_data%0d", k),       32'(data[k]),       32'd0);
            check($sformatf("rst_valid%0d", k),      32'(data_valid[k]), 32'd0);
            check($sformatf("rst_ferr%0d", k),       32'(frame_err[k]),  32'd0);
            check($sformatf("rst_perr%0d", k),       32'(parity_err[k]), 32'd0);
            check($sformatf("rst_busy%0d", k),       32'(busy[k]),       32'd0);
            check($sformatf("rst_tick_en%0d", k),    32'(tick_en[k]),    32'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic 8N1 word
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        idle_gap(0, 20);

        // Even parity: 0x03 has even ones count, so parity bit 1 is wrong
        send_frame(1, 8'h03, 1'b1, 1'b1);
        idle_gap(1, 10);
        send_frame(1, 8'h03, 1'b0, 1'b1);
        idle_gap(1, 10);
        // Odd parity: 0x03 needs parity bit 1
        send_frame(2, 8'h03, 1'b0, 1'b1);
        idle_gap(2, 10);
        send_frame(2, 8'h03, 1'b1, 1'b1);
        idle_gap(2, 10);

        // Randomized frames, including occasional low stop bits
        for (int n = 0; n < 18; n++) begin
            int k;
            k = n % c_NI;
            d = 8'($urandom);
            send_frame(k, d, 1'($urandom), ($urandom % 4) != 0);
            idle_gap(k, 4 + int'($urandom % 40));
        end

        // Glitch: start edge that is high again before the centre sample
        v0   = n_valid[0];
        prev = data[0];
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_busy_in_start", 32'(busy[0]), 32'd1);
        repeat (2) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_after", 32'(busy[0]),    32'd0);
        check("glitch_tick_en",    32'(tick_en[0]), 32'd0);
        check("glitch_no_valid",   32'(n_valid[0]), 32'(v0));
        check("glitch_data_held",  32'(data[0]),    32'(prev));

        // Break: low stop bit then line held low for 30 bit times
        send_frame(0, 8'h00, 1'b0, 1'b0);
        v0 = n_valid[0];
        repeat (15 * c_BIT_CLK) @(negedge clk);
        check("break_busy_mid",    32'(busy[0]),    32'd1);
        check("break_tick_en_mid", 32'(tick_en[0]), 32'd0);
        repeat (15 * c_BIT_CLK) @(negedge clk);
        check("break_busy_end",    32'(busy[0]),    32'd1);
        rxd[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("break_exit_busy",   32'(busy[0]),    32'd0);
        check("break_no_second",   32'(n_valid[0]), 32'(v0));
        idle_gap(0, 20);

        // Back-to-back frames: second start immediately after the first stop
        send_frame(0, 8'h55, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        check("b2b_tick_en_gap", 32'(last_gap[0] >= 1), 32'd1);
        idle_gap(0, 20);

        // Reset pulse in the middle of data bit 3
        d = 8'h5A;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_bit(0, d[i]);
        end
        @(negedge clk);
        rxd[0] = d[3];
        repeat (16) @(negedge clk);
        check("mid_frame_busy", 32'(busy[0]), 32'd1);
        rst    = 1'b1;
        rxd[0] = 1'b1;
        v0     = n_valid[0];
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_data",    32'(data[0]),       32'd0);
        check("rstmid_valid",   32'(data_valid[0]), 32'd0);
        check("rstmid_ferr",    32'(frame_err[0]),  32'd0);
        check("rstmid_perr",    32'(parity_err[0]), 32'd0);
        check("rstmid_busy",    32'(busy[0]),       32'd0);
        check("rstmid_tick_en", 32'(tick_en[0]),    32'd0);
        repeat (12 * c_BIT_CLK) @(negedge clk);
        check("rstmid_no_valid", 32'(n_valid[0]), 32'(v0));
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        idle_gap(0, 20);

        for (int k = 0; k < c_NI; k++) begin
            check($sformatf("queue_drained%0d", k), 32'(q_size(k)), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive deserializer sitting directly downstream of the baud tick generator.
- Consumes the 8x-oversampled rx_tick strobe and the raw RXD pin.
- Drives the generator's enable, so the tick phase restarts on every start-bit edge.
- Recovers 8N1/8E1/8O1 frames and presents each byte with a one-cycle valid pulse plus per-frame error flags to the USART register file.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9); LSB received first.
- OVERSAMPLE, 8, rx_tick strobes per bit period; must match the generator's rx oversampling.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_tick  input  1  one-clk strobe at baud*OVERSAMPLE, from the generator.
- rxd  input  1  asynchronous serial input; idle high.
- tick_en  output  1  enable to the baud generator; 0 holds its accumulator in the restart state.
- data  output  DATA_BITS  last received word; held until the next frame completes.
- data_valid  output  1  one-clk pulse when data, frame_err and parity_err update.
- frame_err  output  1  stop bit sampled 0 in the last frame.
- parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY=0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Input sync: rxd passes through a 2-FF synchronizer (both stages reset to 1); all decisions use the synchronized value rxs, giving 2 clk of latency.
- Reset: state=IDLE, tick_en=0, data=0, data_valid=0, frame_err=0, parity_err=0, busy=0, tick counter=0, bit counter=0. rst mid-frame aborts the frame with no data_valid.
- Tick counter: width clog2(OVERSAMPLE), counts rx_tick only. It is cleared on every state entry and at every sample point. rx_tick is ignored in IDLE and BREAK.
- IDLE:
  - tick_en=0.
  - rxs==0 -> START; tick_en=1 from the next cycle.
- START:
  - On rx_tick number OVERSAMPLE/2 (bit centre), sample rxs.
  - rxs==1 -> glitch; go to IDLE, no flags, no valid.
  - rxs==0 -> DATA, bit counter=0.
- DATA:
  - Every OVERSAMPLE-th rx_tick, shift rxs into the shift register at bit position bit counter.
  - After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
- PARITY:
  - Sample at the next bit centre.
  - Expected value = XOR of data bits (even) or its complement (odd).
  - Go to STOP.
- STOP, at the bit-centre sample:
  - data <= shift register.
  - frame_err <= ~rxs.
  - parity_err <= mismatch.
  - data_valid=1 for exactly one clk.
  - rxs==1 -> IDLE.
  - rxs==0 -> BREAK.
- Back-to-back frames: STOP returns to IDLE at the stop centre, so a start edge arriving half a bit later is caught. tick_en drops for at least 1 clk, which re-phases the generator.
- BREAK:
  - tick_en=0, busy=1.
  - Wait for rxs==1, then IDLE.
  - A stop bit of 0 never launches a new frame by itself.
- Frame length in rx_ticks from START entry to the STOP sample: OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + (PARITY!=0) + 1). This is 76 for 8N1 with OVERSAMPLE=8.
- Simultaneous rx_tick and a state transition: the tick is consumed by the current state only and is never counted twice.
- Error flags are not sticky; they are overwritten at every data_valid.

Test Plan:
- 8N1, rx_tick every 4 clk, send 0xA5 with stop=1 -> one data_valid; data=0xA5; frame_err=0; parity_err=0; busy falls in the same cycle as data_valid.
- rxd low for 2 ticks then high (glitch) -> START aborts at the centre sample; no data_valid; busy back to 0; tick_en back to 0.
- PARITY=1, send 0x03 with parity bit 1 -> parity_err=1, data=0x03. Repeat with parity bit 0 -> parity_err=0.
- Send 0x00 with stop=0 and hold rxd low for 30 bit times -> data_valid with frame_err=1; busy stays 1 in BREAK until rxd rises; no second frame is reported.
- Two back-to-back frames 0x55 then 0xFF, with the second start edge immediately after the first stop bit -> two data_valid pulses with data 0x55 then 0xFF; tick_en deasserts for at least 1 clk between them.
- Assert rst for 1 clk during DATA bit 3 -> all outputs return to reset values; no data_valid. A following clean frame 0x3C is received correctly.
